// File: rtl/read_rsp_merge.sv
// Reorders a split read's NoC responses into one in-order AXI R burst: first segment, then second.
// Zero-latency combinational pass-through; a beat is held on the NoC side until r_ready and its source matches.
module read_rsp_merge #(
  parameter int                  DATA_WIDTH = 128,
  parameter int                  ID_WIDTH   = 4,
  parameter logic [ID_WIDTH-1:0] DEST_ID_PS = ID_WIDTH'(4'b0001),
  parameter logic [ID_WIDTH-1:0] DEST_ID_PL = ID_WIDTH'(4'b0011)
) (
  input  logic                  axi_clk,
  input  logic                  axi_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_WIDTH-1:0]   cmd_first_id,
  input  logic [7:0]            cmd_first_len,
  input  logic                  cmd_split,
  input  logic [7:0]            cmd_second_len,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [ID_WIDTH-1:0]   rsp_src_id,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  input  logic [1:0]            rsp_resp,
  input  logic                  rsp_last,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [1:0]            r_resp,
  output logic                  r_last,
  output logic                  busy,
  output logic                  err_pulse
);

  typedef enum logic [1:0] {IDLE, SEG1, SEG2} state_t;

  state_t              state_q, state_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;
  logic [ID_WIDTH-1:0] first_id_q, first_id_d;
  logic [7:0]          first_len_q, first_len_d;
  logic                split_q, split_d;
  logic [7:0]          second_len_q, second_len_d;
  logic                err_pulse_q, err_pulse_d;

  logic [ID_WIDTH-1:0] expected_id;
  logic [7:0]          seg_len;
  logic                seg_end;
  logic                match;
  logic                xfer;

  always_comb begin
    expected_id = first_id_q;
    seg_len     = first_len_q;
    if (state_q == SEG2) begin
      expected_id = (first_id_q == DEST_ID_PL) ? DEST_ID_PS : DEST_ID_PL;
      seg_len     = second_len_q;
    end
  end

  assign seg_end = (beat_cnt_q == seg_len);
  assign match   = rsp_valid & (rsp_src_id == expected_id) & (state_q != IDLE);
  assign xfer    = match & r_ready;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign r_valid   = match;
  assign rsp_ready = match & r_ready;
  assign r_data    = rsp_data;
  assign r_resp    = rsp_resp;
  // Burst end comes from the descriptor count; rsp_last is only used for framing checks.
  assign r_last    = match & seg_end & ((state_q == SEG2) | ((state_q == SEG1) & ~split_q));
  assign err_pulse = err_pulse_q;

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    first_id_d   = first_id_q;
    first_len_d  = first_len_q;
    split_d      = split_q;
    second_len_d = second_len_q;
    err_pulse_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          first_id_d   = cmd_first_id;
          first_len_d  = cmd_first_len;
          split_d      = cmd_split;
          second_len_d = cmd_second_len;
          beat_cnt_d   = 8'd0;
          state_d      = SEG1;
        end
      end
      SEG1: begin
        if (xfer) begin
          if (seg_end) begin
            beat_cnt_d = 8'd0;
            state_d    = split_q ? SEG2 : IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      SEG2: begin
        if (xfer) begin
          if (seg_end) begin
            beat_cnt_d = 8'd0;
            state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (xfer) begin
      err_pulse_d = (rsp_last != seg_end);
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state_q      <= IDLE;
      beat_cnt_q   <= 8'd0;
      first_id_q   <= '0;
      first_len_q  <= 8'd0;
      split_q      <= 1'b0;
      second_len_q <= 8'd0;
      err_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      first_id_q   <= first_id_d;
      first_len_q  <= first_len_d;
      split_q      <= split_d;
      second_len_q <= second_len_d;
      err_pulse_q  <= err_pulse_d;
    end
  end

endmodule

// File: tb/tb_read_rsp_merge.sv
// Random split-read traffic against a queue model of the expected R stream; a negedge monitor scores every cycle.
module tb_read_rsp_merge;

  localparam logic [3:0] PS = 4'b0001;
  localparam logic [3:0] PL = 4'b0011;

  typedef struct {
    logic [3:0]   src;
    logic [127:0] data;
    logic [1:0]   resp;
    logic         last;
    logic         rlast;
    logic         err;
  } beat_t;

  logic         axi_clk = 1'b0;
  logic         axi_rst;
  logic         cmd_valid, cmd_ready, cmd_split;
  logic [3:0]   cmd_first_id;
  logic [7:0]   cmd_first_len, cmd_second_len;
  logic         rsp_valid, rsp_ready, rsp_last;
  logic [3:0]   rsp_src_id;
  logic [127:0] rsp_data;
  logic [1:0]   rsp_resp;
  logic         r_valid, r_ready, r_last;
  logic [127:0] r_data;
  logic [1:0]   r_resp;
  logic         busy, err_pulse;

  int    n_vec  = 0;
  int    n_fail = 0;
  beat_t exp_q[$];
  beat_t ps_q[$];
  beat_t pl_q[$];
  logic  err_pend = 1'b0;
  logic  exp_rv;
  beat_t hd;

  read_rsp_merge dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_first_id(cmd_first_id),
    .cmd_first_len(cmd_first_len), .cmd_split(cmd_split), .cmd_second_len(cmd_second_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src_id(rsp_src_id),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_last(rsp_last),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .busy(busy), .err_pulse(err_pulse)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] other(input logic [3:0] id);
    return (id == PL) ? PS : PL;
  endfunction

  // Expected behaviour: the next R beat is always the head of exp_q, so only a beat
  // from that head's source may pass; everything else stalls.
  always @(negedge axi_clk) begin
    if (axi_rst) begin
      err_pend = 1'b0;
    end else begin
      exp_rv = rsp_valid && (exp_q.size() > 0) && (rsp_src_id == exp_q[0].src);
      chk("r_valid", r_valid, exp_rv);
      chk("rsp_ready", rsp_ready, exp_rv && r_ready);
      chk("cmd_ready", cmd_ready, exp_q.size() == 0);
      chk("busy", busy, exp_q.size() != 0);
      chk("err_pulse", err_pulse, err_pend);
      err_pend = 1'b0;
      if (exp_rv && r_ready) begin
        hd = exp_q.pop_front();
        chk("r_data", r_data, hd.data);
        chk("r_resp", r_resp, hd.resp);
        chk("r_last", r_last, hd.rlast);
        err_pend = hd.err;
      end
    end
  end

  task automatic do_reset();
    axi_rst = 1'b1;
    @(posedge axi_clk); #1;
    axi_rst = 1'b0;
    exp_q.delete(); ps_q.delete(); pl_q.delete();
  endtask

  // last_shift moves rsp_last earlier in every segment; abort_at resets after that many transfers.
  task automatic run_txn(input logic [3:0] fid, input logic [7:0] flen, input logic split,
                         input logic [7:0] slen, input int corrupt_pct, input int last_shift,
                         input int abort_at, input bit wrong_first);
    beat_t b;
    beat_t ex[$];
    int    nseg, len, budget, nx;
    bit    use_pl, consumed, ok;
    nseg = split ? 2 : 1;
    for (int s = 0; s < nseg; s++) begin
      len = (s == 0) ? int'(flen) : int'(slen);
      for (int i = 0; i <= len; i++) begin
        b.src   = (s == 0) ? fid : other(fid);
        b.data  = {$urandom, $urandom, $urandom, $urandom};
        b.resp  = 2'($urandom_range(3));
        b.last  = (i == len - last_shift) ^ ($urandom_range(99) < corrupt_pct);
        b.rlast = (s == nseg - 1) && (i == len);
        b.err   = (b.last != (i == len));
        ex.push_back(b);
        if (b.src == PL) pl_q.push_back(b); else ps_q.push_back(b);
      end
    end
    @(posedge axi_clk); #1;
    cmd_valid = 1'b1; cmd_first_id = fid; cmd_first_len = flen;
    cmd_split = split; cmd_second_len = slen;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge axi_clk);
      ok = cmd_ready;
      @(posedge axi_clk);
    end
    foreach (ex[k]) exp_q.push_back(ex[k]);
    #1 cmd_valid = 1'b0;
    if (!ok) begin
      chk("cmd_accept_timeout", 1'b0, 1'b1);
      do_reset();
      return;
    end
    use_pl = wrong_first ? (other(fid) == PL) : (fid == PL);
    budget = 20000;
    nx = 0;
    while ((ps_q.size() + pl_q.size()) > 0 && budget > 0) begin
      if (ps_q.size() == 0) use_pl = 1'b1;
      else if (pl_q.size() == 0) use_pl = 1'b0;
      else if ($urandom_range(2) == 0) use_pl = !use_pl;
      b = use_pl ? pl_q[0] : ps_q[0];
      rsp_valid  = ($urandom_range(7) != 0);
      rsp_src_id = b.src; rsp_data = b.data; rsp_resp = b.resp; rsp_last = b.last;
      r_ready    = ($urandom_range(2) != 0);
      @(negedge axi_clk);
      consumed = rsp_valid && rsp_ready;
      @(posedge axi_clk); #1;
      if (consumed) begin
        if (use_pl) void'(pl_q.pop_front()); else void'(ps_q.pop_front());
        nx++;
      end
      budget--;
      if (abort_at >= 0 && nx == abort_at) begin
        rsp_valid = 1'b1; rsp_src_id = other(fid); r_ready = 1'b1;
        do_reset();
        @(negedge axi_clk);
        chk("abort_cmd_ready", cmd_ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_r_valid", r_valid, 1'b0);
        @(posedge axi_clk); #1;
        rsp_valid = 1'b0;
        return;
      end
    end
    rsp_valid = 1'b0; r_ready = 1'b1;
    if (budget == 0) begin
      chk("rsp_drain_timeout", 1'b0, 1'b1);
      do_reset();
    end
  endtask

  initial begin
    axi_rst = 1'b1; cmd_valid = 1'b0; cmd_first_id = '0; cmd_first_len = '0;
    cmd_split = 1'b0; cmd_second_len = '0; rsp_valid = 1'b1; rsp_src_id = PS;
    rsp_data = '0; rsp_resp = '0; rsp_last = 1'b0; r_ready = 1'b1;
    repeat (3) @(posedge axi_clk);
    #1 axi_rst = 1'b0;
    @(negedge axi_clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_r_valid", r_valid, 1'b0);
    chk("rst_rsp_ready", rsp_ready, 1'b0);
    chk("rst_r_last", r_last, 1'b0);
    chk("rst_err_pulse", err_pulse, 1'b0);
    @(posedge axi_clk); #1 rsp_valid = 1'b0;

    run_txn(PL, 8'd3, 1'b0, 8'd0, 0, 0, -1, 1'b0);
    run_txn(PS, 8'd1, 1'b1, 8'd2, 0, 0, -1, 1'b0);
    run_txn(PL, 8'd2, 1'b1, 8'd1, 0, 0, -1, 1'b1);
    run_txn(PL, 8'd3, 1'b0, 8'd0, 0, 0, -1, 1'b0);
    run_txn(PS, 8'd2, 1'b0, 8'd0, 0, 1, -1, 1'b0);
    run_txn(PS, 8'd1, 1'b1, 8'd3, 0, 0, 3, 1'b0);
    run_txn(PL, 8'd0, 1'b1, 8'd0, 0, 0, -1, 1'b1);
    run_txn(PS, 8'd255, 1'b1, 8'd2, 0, 0, -1, 1'b0);
    for (int t = 0; t < 40; t++) begin
      run_txn(($urandom_range(1) != 0) ? PL : PS, 8'($urandom_range(6)),
              1'($urandom_range(1)), 8'($urandom_range(6)), 15, 0, -1,
              1'($urandom_range(1)));
    end
    repeat (3) @(posedge axi_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
